// File: rtl/alu_tx_pkg.sv
// Shared constants for the ALU result serial transmitter:
// state encoding, state width and the default bit period.
package alu_tx_pkg;

    localparam int NB_STATE             = 3;
    localparam int DEFAULT_CLKS_PER_BIT = 868;   // 100 MHz / 115200 baud

    typedef enum logic [NB_STATE-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter for the serial transmitter.
// Counts 0..CLKS_PER_BIT-1 and wraps; o_tick is high for the single cycle
// in which the counter sits at its last value, so the owner advances on
// the edge that wraps the count. i_restart forces the count back to 0.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign o_tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // Next count: restart, wrap on the bit boundary, or increment.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_restart || o_tick) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_result_tx.sv
// Serial (8N1-style) transmitter for ALU results.
// Captures i_data on an i_start pulse seen in IDLE and shifts it out LSB
// first as start / data / [parity] / stop bits on o_tx. All outputs are
// registered. o_state mirrors the FSM state for observation.
// Optional feature: define ALU_RESULT_TX_PARITY_EN to insert an even
// parity bit after the data bits.
//
// Handshake: i_start is a request sampled only while idle (o_busy low);
// the word is taken on that edge, o_busy rises on the next cycle and
// stays high until the frame ends; o_done pulses for the first idle cycle,
// in which a new request is already accepted. Requests while busy are
// dropped.
module alu_result_tx
    import alu_tx_pkg::*;
#(
    parameter int NB_DATA      = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int NB_STOP      = 1
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_DATA-1:0]  i_data,
    output logic                o_tx,
    output logic                o_busy,
    output logic                o_done,
    output logic [NB_STATE-1:0] o_state
);

    localparam int MAX_BITS = (NB_DATA > NB_STOP) ? NB_DATA : NB_STOP;
    localparam int BIT_W    = $clog2(MAX_BITS + 1);

    tx_state_e          state_q, state_d;
    logic [NB_DATA-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               restart;
    logic               bit_tick;
`ifdef ALU_RESULT_TX_PARITY_EN
    logic               par_q, par_d;
`endif

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_restart(restart),
        .o_tick   (bit_tick)
    );

    // Next state, shift register, bit counter and the output values that
    // belong to the next state (so outputs come straight from flops).
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        done_d  = 1'b0;
        restart = 1'b0;
`ifdef ALU_RESULT_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Hold the bit timer at 0 so the start bit gets a full period.
                restart = 1'b1;
                if (i_start) begin
                    state_d = ST_START;
                    shift_d = i_data;
                    bit_d   = '0;
`ifdef ALU_RESULT_TX_PARITY_EN
                    par_d   = ^i_data;
`endif
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_q == BIT_W'(NB_DATA - 1)) begin
`ifdef ALU_RESULT_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                        bit_d   = '0;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef ALU_RESULT_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                end
            end
`endif
            ST_STOP: begin
                if (bit_tick) begin
                    if (bit_q == BIT_W'(NB_STOP - 1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef ALU_RESULT_TX_PARITY_EN
            ST_PARITY: tx_d = par_q;
`endif
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers; reset aborts any frame with the line high.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_RESULT_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ALU_RESULT_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign o_tx    = tx_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_alu_result_tx.sv
// Self-checking bench for alu_result_tx (CLKS_PER_BIT=4, NB_DATA=8, NB_STOP=1).
// Expected line waveforms come from a frame model that lists the bits of a
// UART frame and repeats each for one bit period.
module tb_alu_result_tx;
    import alu_tx_pkg::*;

    localparam int C  = 4;
`ifdef ALU_RESULT_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = (1 + 8 + PAR + 1) * C;

    logic                clock;
    logic                i_reset;
    logic                i_start;
    logic [7:0]          i_data;
    logic                o_tx;
    logic                o_busy;
    logic                o_done;
    logic [NB_STATE-1:0] o_state;

    int checks;
    int errors;
    logic [0:0] exp_q[$];

    alu_result_tx #(
        .NB_DATA     (8),
        .CLKS_PER_BIT(C),
        .NB_STOP     (1)
    ) dut (
        .clock  (clock),
        .i_reset(i_reset),
        .i_start(i_start),
        .i_data (i_data),
        .o_tx   (o_tx),
        .o_busy (o_busy),
        .o_done (o_done),
        .o_state(o_state)
    );

    // Clock and watchdog
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    // Reference model: bit list of one frame, each bit held C cycles.
    task automatic build_frame(input logic [7:0] d);
        logic bits[$];
        exp_q.delete();
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (PAR == 1) begin
            int ones = 0;
            for (int i = 0; i < 8; i++) ones += int'(d[i]);
            bits.push_back((ones % 2) == 1);
        end
        bits.push_back(1'b1);
        foreach (bits[b]) for (int k = 0; k < C; k++) exp_q.push_back(bits[b]);
    endtask

    // Drivers (caller sits at a negedge)
    task automatic start_frame(input logic [7:0] d);
        i_start = 1'b1;
        i_data  = d;
        @(negedge clock);
    endtask

    // Checks a frame already accepted; caller is at the negedge of its
    // first cycle. hold keeps i_start high and scribbles i_data meanwhile.
    task automatic check_frame(input logic [7:0] d, input bit hold, input logic [7:0] junk);
        int n;
        int tx_bad;
        int busy_bad;
        int done_bad;
        build_frame(d);
        n = 0;
        tx_bad = 0; busy_bad = 0; done_bad = 0;
        if (exp_q.size() != FL) begin
            errors++;
            $display("FAIL frame_len_model: got %0d, need %0d", exp_q.size(), FL);
        end
        while (exp_q.size() > 0) begin
            logic [0:0] e;
            e = exp_q.pop_front();
            checks++;
            if (o_tx !== e[0] || o_busy !== 1'b1 || o_done !== 1'b0) begin
                errors++;
                if (o_tx !== e[0]) tx_bad++;
                if (o_busy !== 1'b1) busy_bad++;
                if (o_done !== 1'b0) done_bad++;
                if (tx_bad + busy_bad + done_bad < 4)
                    $display("FAIL frame_cycle data=%h cyc=%0d: got tx=%b busy=%b done=%b, need tx=%b busy=1 done=0",
                             d, n + 1, o_tx, o_busy, o_done, e[0]);
            end
            if (hold && n < FL - 1) begin
                i_start = 1'b1;
                i_data  = junk;
            end else begin
                i_start = 1'b0;
            end
            n++;
            @(negedge clock);
        end
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_tx !== 1'b1) begin
            errors++;
            $display("FAIL done_cycle data=%h cyc=%0d: got done=%b busy=%b tx=%b, need done=1 busy=0 tx=1",
                     d, FL + 1, o_done, o_busy, o_tx);
        end
    endtask

    task automatic check_idle(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            checks++;
            if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
                errors++;
                $display("FAIL %s: got tx=%b busy=%b done=%b, need tx=1 busy=0 done=0",
                         name, o_tx, o_busy, o_done);
            end
        end
    endtask

    // Scenarios
    task automatic test_reset();
        i_reset = 1'b1; i_start = 1'b0; i_data = 8'h00;
        repeat (3) @(negedge clock);
        checks++;
        if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got tx=%b busy=%b done=%b state=%0d, need 1 0 0 %0d",
                     o_tx, o_busy, o_done, o_state, ST_IDLE);
        end
        i_reset = 1'b0;
        @(negedge clock);
        // Start a frame and abort it mid-data.
        start_frame(8'h00);
        i_start = 1'b0;
        repeat (10) @(negedge clock);
        checks++;
        if (o_tx !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_abort: got tx=%b busy=%b, need tx=0 busy=1", o_tx, o_busy);
        end
        i_reset = 1'b1;
        #1;
        checks++;
        if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL async_abort: got tx=%b busy=%b done=%b, need 1 0 0", o_tx, o_busy, o_done);
        end
        @(negedge clock);
        i_reset = 1'b0;
        check_idle("post_abort_idle", 3);
        start_frame(8'h5A);
        check_frame(8'h5A, 1'b0, 8'h00);
    endtask

    task automatic test_a5();
        @(negedge clock);
        start_frame(8'hA5);
        check_frame(8'hA5, 1'b0, 8'h00);
        check_idle("a5_after", 2);
    endtask

    task automatic test_start_ignored();
        @(negedge clock);
        start_frame(8'hA5);
        check_frame(8'hA5, 1'b1, 8'h00);
        check_idle("no_second_frame", 2 * C);
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        start_frame(8'hC3);
        check_frame(8'hC3, 1'b0, 8'h00);
        // Now in the o_done cycle: request again right here.
        start_frame(8'h3C);
        check_frame(8'h3C, 1'b0, 8'h00);
        check_idle("b2b_after", 2);
    endtask

    task automatic test_parity_len();
        // 8'h07 has three ones: parity bit 1 when enabled; length FL.
        @(negedge clock);
        start_frame(8'h07);
        check_frame(8'h07, 1'b0, 8'h00);
    endtask

    task automatic test_extremes();
        @(negedge clock);
        start_frame(8'hFF);
        check_frame(8'hFF, 1'b0, 8'h00);
        start_frame(8'h00);
        check_frame(8'h00, 1'b0, 8'h00);
        check_idle("extreme_after", 2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) @(negedge clock);
            start_frame(d);
            check_frame(d, ($urandom_range(0, 1) == 1), 8'($urandom));
        end
        check_idle("random_after", 2);
    endtask

    // Sequence and report
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_a5();
        test_start_ignored();
        test_back_to_back();
        test_parity_len();
        test_extremes();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
